// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: fetch, decode and execute of a small 16-bit ISA.
// Strobes are pure functions of the state register and ir, and are forced low while rst is low.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus,
    input  logic        MFC,
    output logic [2:0]  opControl,
    output logic        ALUin0,
    output logic        ALUin1,
    output logic        ALUOutLatch,
    output logic        ALUOutEn,
    output logic        PCOutEn,
    output logic        r0Latch,
    output logic        r1Latch,
    output logic        r2Latch,
    output logic        r3Latch,
    output logic        r0Out,
    output logic        r1Out,
    output logic        r2Out,
    output logic        r3Out,
    output logic        memEN,
    output logic        memRW,
    output logic        MARin,
    output logic        MDRwriteEN,
    output logic        MDRreadEN,
    output logic        MDRout,
    output logic        p0Latch,
    output logic        p0Out,
    output logic        p1Latch,
    output logic        p1Out,
    output logic        halted,
    output logic        fault,
    output logic [15:0] ir
);

    typedef enum logic [4:0] {
        StF0, StF1, StF2, StF3, StDecode,
        StAlu0, StAlu1, StAlu2, StAlu3,
        StLd0, StLd1, StLd2, StLd3,
        StSt0, StSt1, StSt2,
        StMov, StOut, StIn0, StIn1,
        StHalt, StFault
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] ir_q;
    logic [3:0]  rd_sel, rs_sel;
    logic [3:0]  r_out, r_latch;

    assign rd_sel = 4'b0001 << ir_q[11:10];
    assign rs_sel = 4'b0001 << ir_q[9:8];
    assign ir     = ir_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StF0;
            wait_q  <= 4'd0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StF3) begin
                ir_q <= bus;
            end
        end
    end

    // wait_d defaults to 0 so the counter is clear on entry to every memory-wait step.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            StF0:     state_d = StF1;
            StF1, StLd1, StSt2: begin
                if (MFC) begin
                    state_d = (state_q == StF1)  ? StF2 :
                              (state_q == StLd1) ? StLd2 : StF0;
                end else if (wait_q == 4'hf) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StF2:     state_d = StF3;
            StF3:     state_d = StDecode;
            StDecode: begin
                if (ir_q[15]) begin
                    state_d = StAlu0;
                end else begin
                    case (ir_q[14:12])
                        3'd1:    state_d = StLd0;
                        3'd2:    state_d = StSt0;
                        3'd3:    state_d = StMov;
                        3'd4:    state_d = StOut;
                        3'd5:    state_d = StIn0;
                        3'd6:    state_d = StHalt;
                        default: state_d = StF0;
                    endcase
                end
            end
            StAlu0:   state_d = StAlu1;
            StAlu1:   state_d = StAlu2;
            StAlu2:   state_d = StAlu3;
            StLd0:    state_d = StLd1;
            StLd2:    state_d = StLd3;
            StSt0:    state_d = StSt1;
            StSt1:    state_d = StSt2;
            StIn0:    state_d = StIn1;
            StAlu3, StLd3, StMov, StOut, StIn1: state_d = StF0;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        opControl   = 3'd0;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        ALUOutLatch = 1'b0;
        ALUOutEn    = 1'b0;
        PCOutEn     = 1'b0;
        r_out       = 4'd0;
        r_latch     = 4'd0;
        memEN       = 1'b0;
        memRW       = 1'b0;
        MARin       = 1'b0;
        MDRwriteEN  = 1'b0;
        MDRreadEN   = 1'b0;
        MDRout      = 1'b0;
        p0Latch     = 1'b0;
        p0Out       = 1'b0;
        p1Latch     = 1'b0;
        p1Out       = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        if (rst) begin
            case (state_q)
                StF0:    begin PCOutEn = 1'b1; MARin = 1'b1; end
                StF1:    begin memEN = 1'b1; memRW = 1'b1; end
                StF2:    MDRreadEN = 1'b1;
                StF3:    MDRout = 1'b1;
                StAlu0:  begin opControl = ir_q[14:12]; r_out = rd_sel; ALUin0 = 1'b1; end
                StAlu1:  begin opControl = ir_q[14:12]; r_out = rs_sel; ALUin1 = 1'b1; end
                StAlu2:  begin opControl = ir_q[14:12]; ALUOutLatch = 1'b1; end
                StAlu3:  begin opControl = ir_q[14:12]; ALUOutEn = 1'b1; r_latch = rd_sel; end
                StLd0:   begin r_out = rs_sel; MARin = 1'b1; end
                StLd1:   begin memEN = 1'b1; memRW = 1'b1; end
                StLd2:   MDRreadEN = 1'b1;
                StLd3:   begin MDRout = 1'b1; r_latch = rd_sel; end
                StSt0:   begin r_out = rs_sel; MARin = 1'b1; end
                StSt1:   begin r_out = rd_sel; MDRwriteEN = 1'b1; end
                StSt2:   memEN = 1'b1;
                StMov:   begin r_out = rs_sel; r_latch = rd_sel; end
                StOut:   begin r_out = rd_sel; p0Latch = 1'b1; end
                StIn0:   p1Latch = 1'b1;
                StIn1:   begin p1Out = 1'b1; r_latch = rd_sel; end
                StHalt:  halted = 1'b1;
                StFault: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign {r3Out, r2Out, r1Out, r0Out}         = r_out;
    assign {r3Latch, r2Latch, r1Latch, r0Latch} = r_latch;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer with a bus-exclusivity monitor.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bus = 16'h0;
    logic        MFC = 1'b0;
    logic [2:0]  opControl;
    logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn;
    logic        r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out;
    logic        memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout;
    logic        p0Latch, p0Out, p1Latch, p1Out, halted, fault;
    logic [15:0] ir;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .bus(bus), .MFC(MFC), .opControl(opControl),
        .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
        .PCOutEn(PCOutEn), .r0Latch(r0Latch), .r1Latch(r1Latch), .r2Latch(r2Latch),
        .r3Latch(r3Latch), .r0Out(r0Out), .r1Out(r1Out), .r2Out(r2Out), .r3Out(r3Out),
        .memEN(memEN), .memRW(memRW), .MARin(MARin), .MDRwriteEN(MDRwriteEN),
        .MDRreadEN(MDRreadEN), .MDRout(MDRout), .p0Latch(p0Latch), .p0Out(p0Out),
        .p1Latch(p1Latch), .p1Out(p1Out), .halted(halted), .fault(fault), .ir(ir)
    );

    logic [27:0] outs;
    assign outs = {opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn,
                   r3Latch, r2Latch, r1Latch, r0Latch, r3Out, r2Out, r1Out, r0Out,
                   memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout,
                   p0Latch, p0Out, p1Latch, p1Out, halted, fault};

    localparam logic [27:0] FLT   = 28'h1 << 0;
    localparam logic [27:0] HLT   = 28'h1 << 1;
    localparam logic [27:0] P1OUT = 28'h1 << 2;
    localparam logic [27:0] P1L   = 28'h1 << 3;
    localparam logic [27:0] P0L   = 28'h1 << 5;
    localparam logic [27:0] MDROT = 28'h1 << 6;
    localparam logic [27:0] MDRRD = 28'h1 << 7;
    localparam logic [27:0] MDRWR = 28'h1 << 8;
    localparam logic [27:0] MAR   = 28'h1 << 9;
    localparam logic [27:0] RW    = 28'h1 << 10;
    localparam logic [27:0] MEM   = 28'h1 << 11;
    localparam logic [27:0] R0O   = 28'h1 << 12;
    localparam logic [27:0] R1O   = 28'h1 << 13;
    localparam logic [27:0] R2O   = 28'h1 << 14;
    localparam logic [27:0] R3O   = 28'h1 << 15;
    localparam logic [27:0] R1L   = 28'h1 << 17;
    localparam logic [27:0] R2L   = 28'h1 << 18;
    localparam logic [27:0] PCO   = 28'h1 << 20;
    localparam logic [27:0] AOE   = 28'h1 << 21;
    localparam logic [27:0] AOL   = 28'h1 << 22;
    localparam logic [27:0] AIN1  = 28'h1 << 23;
    localparam logic [27:0] AIN0  = 28'h1 << 24;
    localparam logic [27:0] OP1   = 28'h1 << 25;

    typedef struct {
        logic        mfc;
        logic [15:0] bus;
        logic [27:0] exp;
        logic [15:0] ir;
    } row_t;

    row_t        vec[$];
    logic [15:0] exp_ir;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endfunction

    function automatic void add(input logic m, input logic [15:0] b, input logic [27:0] e);
        row_t r;
        r.mfc = m;
        r.bus = b;
        r.exp = e;
        r.ir  = exp_ir;
        vec.push_back(r);
    endfunction

    // One-cycle memory wait: F0, F1 (MFC=1), F2, F3, then DECODE with the new ir.
    function automatic void fetch(input logic [15:0] instr);
        add(1'b0, 16'h0, PCO | MAR);
        add(1'b1, 16'h0, MEM | RW);
        add(1'b0, 16'h0, MDRRD);
        add(1'b0, instr, MDROT);
        exp_ir = instr;
        add(1'b1, 16'h0, 28'h0);
    endfunction

    task automatic run_rows(input string tag);
        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            MFC = vec[i].mfc;
            bus = vec[i].bus;
            check($sformatf("%s[%0d].out", tag, i), 32'(outs), 32'(vec[i].exp));
            check($sformatf("%s[%0d].ir", tag, i), 32'(ir), 32'(vec[i].ir));
        end
        vec.delete();
    endtask

    // Released just after a rising edge so the next falling edge shows the first F0 cycle.
    task automatic reset_dut();
        rst = 1'b0;
        MFC = 1'b0;
        bus = 16'h0;
        exp_ir = 16'h0;
        @(posedge clk);
        #1;
        check("reset.out", 32'(outs), 32'h0);
        check("reset.ir", 32'(ir), 32'h0);
        #1 rst = 1'b1;
    endtask

    // Drive-enable exclusivity on the shared bus, every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            int n;
            n = int'(ALUOutEn) + int'(PCOutEn) + int'(r0Out) + int'(r1Out) + int'(r2Out)
              + int'(r3Out) + int'(MDRout) + int'(p0Out) + int'(p1Out);
            n_checks++;
            if (n <= 1) n_pass++;
            else $display("FAIL bus_excl: %0d drivers, want at most 1", n);
        end
    end

    initial begin
        reset_dut();

        // Fetch of 0x9600 with MFC on the third F1 cycle, then the ALU sequence.
        add(1'b0, 16'h0, PCO | MAR);
        add(1'b0, 16'h0, MEM | RW);
        add(1'b0, 16'h0, MEM | RW);
        add(1'b1, 16'h0, MEM | RW);
        add(1'b0, 16'h0, MDRRD);
        add(1'b0, 16'h9600, MDROT);
        exp_ir = 16'h9600;
        add(1'b0, 16'h0, 28'h0);
        add(1'b0, 16'h0, OP1 | R1O | AIN0);
        add(1'b0, 16'h0, OP1 | R2O | AIN1);
        add(1'b0, 16'h0, OP1 | AOL);
        add(1'b0, 16'h0, OP1 | AOE | R1L);
        // STORE [r3], r0 with a two-cycle write wait.
        fetch(16'h2300);
        add(1'b0, 16'h0, R3O | MAR);
        add(1'b0, 16'h0, R0O | MDRWR);
        add(1'b0, 16'h0, MEM);
        add(1'b1, 16'h0, MEM);
        // LOAD r2, [r1]; MFC pulses outside the wait step are ignored.
        fetch(16'h1900);
        add(1'b1, 16'h0, R1O | MAR);
        add(1'b0, 16'h0, MEM | RW);
        add(1'b1, 16'h0, MEM | RW);
        add(1'b0, 16'h0, MDRRD);
        add(1'b0, 16'h0, MDROT | R2L);
        fetch(16'h3600);
        add(1'b0, 16'h0, R2O | R1L);
        fetch(16'h4c00);
        add(1'b0, 16'h0, R3O | P0L);
        fetch(16'h5400);
        add(1'b0, 16'h0, P1L);
        add(1'b0, 16'h0, P1OUT | R1L);
        fetch(16'h7000);
        fetch(16'h0000);
        add(1'b0, 16'h0, PCO | MAR);
        run_rows("prog");

        // Asynchronous reset in the middle of an F1 memory request.
        @(negedge clk);
        MFC = 1'b0;
        check("f1_before_rst.out", 32'(outs), 32'(MEM | RW));
        #1 rst = 1'b0;
        #1;
        check("async_rst.out", 32'(outs), 32'h0);
        check("async_rst.ir", 32'(ir), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_c1.out", 32'(outs), 32'(PCO | MAR));
        @(negedge clk);
        check("post_rst_c2.out", 32'(outs), 32'(MEM | RW));

        // MFC on the 16th wait cycle still completes the fetch.
        reset_dut();
        add(1'b0, 16'h0, PCO | MAR);
        for (int i = 0; i < 15; i++) add(1'b0, 16'h0, MEM | RW);
        add(1'b1, 16'h0, MEM | RW);
        add(1'b0, 16'h0, MDRRD);
        run_rows("wait16");

        // No MFC: exactly 16 wait cycles, then FAULT that ignores MFC.
        reset_dut();
        add(1'b0, 16'h0, PCO | MAR);
        for (int i = 0; i < 16; i++) add(1'b0, 16'h0, MEM | RW);
        for (int i = 0; i < 6; i++) add(1'(i % 2), 16'h0, FLT);
        run_rows("fault");

        // HALT holds with no strobes for 100 cycles regardless of MFC.
        reset_dut();
        fetch(16'h6000);
        for (int i = 0; i < 100; i++) add(1'($urandom_range(0, 1)), 16'h0, HLT);
        run_rows("halt");

        // Random instruction stream; only the exclusivity monitor judges this part.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus = 16'($urandom);
            MFC = ($urandom_range(0, 2) == 0);
            if (halted || fault) begin
                rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port bus, input, 16 bits: shared datapath bus value, sampled for instruction capture.
REQ-004 The block SHALL have the port MFC, input, 1 bit: memory function complete, sampled synchronously.
REQ-005 The block SHALL have the port opControl, output, 3 bits: ALU operation select.
REQ-006 The block SHALL have the ports ALUin0, ALUin1, ALUOutLatch and ALUOutEn, outputs, 1 bit each: ALU input-register latches, output-register latch and output bus enable.
REQ-007 The block SHALL have the port PCOutEn, output, 1 bit: program counter bus enable.
REQ-008 The block SHALL have the ports r0Latch..r3Latch and r0Out..r3Out, outputs, 1 bit each: general register latch and bus enable.
REQ-009 The block SHALL have the ports memEN and memRW, outputs, 1 bit each: memory request; memRW=1 read, 0 write.
REQ-010 The block SHALL have the ports MARin, MDRwriteEN, MDRreadEN and MDRout, outputs, 1 bit each: address and data register controls.
REQ-011 The block SHALL have the ports p0Latch, p0Out, p1Latch and p1Out, outputs, 1 bit each: I/O port controls.
REQ-012 The block SHALL have the ports halted and fault, outputs, 1 bit each; and ir, output, 16 bits: current instruction.

Function
REQ-013 All control outputs SHALL be registered (Moore); each strobe SHALL be high for exactly one clock per step unless stated otherwise.
REQ-014 At most one of ALUOutEn, PCOutEn, r0Out..r3Out, MDRout, p0Out, p1Out SHALL be high in any cycle.
REQ-015 Fetch SHALL use states F0, F1, F2, F3, then DECODE:
- F0: PCOutEn + MARin.
- F1: memEN=1, memRW=1, held until MFC=1.
- F2: MDRreadEN.
- F3: MDRout; ir loads bus at the edge ending F3.
REQ-016 The instruction fields SHALL be: ir[15:12] opcode, ir[11:10] rd, ir[9:8] rs; ir[7:0] is ignored.
REQ-017 When ir[15]=1 (ALU operation), execute SHALL take four cycles, with opControl=ir[14:12] held for all four:
- rdOut + ALUin0.
- rsOut + ALUin1.
- ALUOutLatch.
- ALUOutEn + rdLatch.
REQ-018 Opcode 0001 (LOAD rd,[rs]) SHALL execute as:
- rsOut + MARin.
- memEN, memRW=1 until MFC.
- MDRreadEN.
- MDRout + rdLatch.
REQ-019 Opcode 0010 (STORE [rs],rd) SHALL execute as:
- rsOut + MARin.
- rdOut + MDRwriteEN.
- memEN, memRW=0 until MFC.
REQ-020 Opcode 0011 (MOV) SHALL execute as rsOut + rdLatch in one cycle.
REQ-021 Opcode 0100 (OUT) SHALL execute as rdOut + p0Latch in one cycle.
REQ-022 Opcode 0101 (IN) SHALL execute as p1Latch, then p1Out + rdLatch.
REQ-023 Opcodes 0000 and 0111 SHALL be NOPs; opcode 0110 (HALT) SHALL enter HALT, set halted=1 and assert no strobes until reset.
REQ-024 After the last execute step the block SHALL return to F0 on the next cycle; DECODE SHALL be one cycle with no strobes.
REQ-025 Memory wait:
- A 4-bit wait counter SHALL clear on entry to any memory-wait step and increment each cycle MFC=0.
- MFC=1 in any wait cycle (including the 16th) SHALL end the wait and deassert memEN next cycle.
- If MFC=0 in the 16th wait cycle, the block SHALL enter FAULT: fault=1, all strobes 0, held until reset.
REQ-026 MFC SHALL be ignored outside memory-wait steps.
REQ-027 When rst is asserted, all outputs SHALL go to 0 immediately, including ir=0x0000, halted=0 and fault=0; any in-progress memory request SHALL be dropped.

Reset
REQ-028 On rst deassertion the state SHALL be F0, and PCOutEn+MARin SHALL be high in the first clock.
REQ-029 The wait counter SHALL reset to 0.

Verification
REQ-030 The bench SHALL drive rst low during F1 with memEN=1 -> memEN=0 asynchronously, ir=0; after release, cycle 1 shows PCOutEn=1 and MARin=1.
REQ-031 The bench SHALL run a fetch with MFC raised on the 3rd F1 cycle and bus=0x9600 in F3 -> memEN high 3 cycles; ir=0x9600; then r1Out+ALUin0, r2Out+ALUin1, ALUOutLatch, ALUOutEn+r1Latch, with opControl=001 throughout.
REQ-032 The bench SHALL run ir=0x2300 (STORE) -> r3Out+MARin, r0Out+MDRwriteEN, then memEN=1 with memRW=0 until MFC, then F0.
REQ-033 The bench SHALL hold MFC=0 during a fetch -> memEN high for exactly 16 cycles, then fault=1 with all strobes 0 until rst.
REQ-034 The bench SHALL fetch 0x6000 (HALT) -> halted=1, no strobes for 100 cycles, and MFC pulses ignored.
REQ-035 The bench SHALL run a random program -> REQ-014 bus exclusivity checked every cycle.
